// File: rtl/pc_sequencer_if.sv
// Control/ALU to fetch-address handshake bundle for pc_sequencer.
// master drives the step controls; slave returns the fetch address and status.
interface pc_sequencer_if #(
   parameter int PC_BITS     = 9,
   parameter int TARGET_BITS = 8
);
   logic                   start;
   logic                   stall;
   logic                   next_ins;
   logic                   jump_flag;
   logic [1:0]             jump_mode;
   logic [TARGET_BITS-1:0] target;
   logic [PC_BITS-1:0]     pc_out;
   logic                   busy;
   logic                   done;
   logic                   stack_overflow;
   logic                   stack_underflow;

   modport master (
      output start, stall, next_ins, jump_flag, jump_mode, target,
      input  pc_out, busy, done, stack_overflow, stack_underflow
   );

   modport slave (
      input  start, stall, next_ins, jump_flag, jump_mode, target,
      output pc_out, busy, done, stack_overflow, stack_underflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with start/run/done FSM, abs/rel/call/return jumps and a return-address stack.
// Latency: one registered update per cycle; stall or next_ins=0 holds pc_out.
module pc_sequencer #(
   parameter int PC_BITS     = 9,
   parameter int TARGET_BITS = 8,
   parameter int STACK_DEPTH = 4,
   parameter int START_ADDR  = 0,
   parameter int DONE_ADDR   = 435
) (
   input  logic          clock,
   input  logic          reset_n,
   pc_sequencer_if.slave bus
);
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [PC_BITS-1:0] START_PC = PC_BITS'(START_ADDR);
   localparam logic [PC_BITS-1:0] DONE_PC  = PC_BITS'(DONE_ADDR);
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(STACK_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [PC_BITS-1:0] pc, pc_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               ovf, ovf_n;
   logic               unf, unf_n;
   logic               push;
   logic [PC_BITS-1:0] stack [STACK_DEPTH];

   logic [PC_BITS-1:0] pc_inc;
   logic [PC_BITS-1:0] tgt_zx;
   logic [PC_BITS-1:0] tgt_sx;
   logic [IDX_W-1:0]   push_idx;
   logic [IDX_W-1:0]   pop_idx;

   assign pc_inc   = pc + 1'b1;
   assign tgt_zx   = PC_BITS'(bus.target);
   assign tgt_sx   = PC_BITS'($signed(bus.target));
   assign push_idx = IDX_W'(cnt);
   assign pop_idx  = IDX_W'(cnt - 1'b1);

   always_comb begin
      state_n = state;
      pc_n    = pc;
      cnt_n   = cnt;
      ovf_n   = ovf;
      unf_n   = unf;
      push    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = RUN;
               pc_n    = START_PC;
               cnt_n   = '0;
               ovf_n   = 1'b0;
               unf_n   = 1'b0;
            end
         end
         RUN: begin
            // Arrival at DONE_ADDR wins over whatever step is requested this cycle.
            if (pc == DONE_PC) begin
               state_n = DONE;
            end else if (bus.next_ins && !bus.stall) begin
               if (!bus.jump_flag) begin
                  pc_n = pc_inc;
               end else begin
                  case (bus.jump_mode)
                     2'b00: pc_n = tgt_zx;
                     2'b01: pc_n = pc + tgt_sx;
                     2'b10: begin
                        if (cnt == FULL_CNT) begin
                           pc_n  = pc_inc;
                           ovf_n = 1'b1;
                        end else begin
                           push  = 1'b1;
                           cnt_n = cnt + 1'b1;
                           pc_n  = tgt_zx;
                        end
                     end
                     default: begin
                        if (cnt == '0) begin
                           pc_n  = pc_inc;
                           unf_n = 1'b1;
                        end else begin
                           pc_n  = stack[pop_idx];
                           cnt_n = cnt - 1'b1;
                        end
                     end
                  endcase
               end
            end
         end
         DONE: begin
            pc_n = DONE_PC;
            if (bus.start) begin
               state_n = RUN;
               pc_n    = START_PC;
               cnt_n   = '0;
               ovf_n   = 1'b0;
               unf_n   = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            pc_n    = START_PC;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
         pc    <= START_PC;
         cnt   <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         cnt   <= cnt_n;
         ovf   <= ovf_n;
         unf   <= unf_n;
      end
   end

   // Entries above cnt are don't-care, so the storage itself needs no reset.
   always_ff @(posedge clock) begin
      if (push) stack[push_idx] <= pc_inc;
   end

   assign bus.pc_out          = pc;
   assign bus.busy            = (state == RUN);
   assign bus.done            = (state == DONE);
   assign bus.stack_overflow  = ovf;
   assign bus.stack_underflow = unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: counting, wrap, jumps, call/return stack, done, stall, reset.
module tb_pc_sequencer;
   logic clock = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   pc_sequencer_if #(.PC_BITS(9), .TARGET_BITS(8)) bus ();

   pc_sequencer #(
      .PC_BITS(9), .TARGET_BITS(8), .STACK_DEPTH(4), .START_ADDR(0), .DONE_ADDR(435)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ni, input logic jf, input logic [1:0] jm, input logic [7:0] tg);
      bus.next_ins  = ni;
      bus.jump_flag = jf;
      bus.jump_mode = jm;
      bus.target    = tg;
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.start     = 1'b0;
      bus.stall     = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 8'd0);
      step();
      chk("rst_pc", 32'(bus.pc_out), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_ovf", 32'(bus.stack_overflow), 0);
      chk("rst_unf", 32'(bus.stack_underflow), 0);

      reset_n = 1'b1; bus.start = 1'b1;
      step();
      chk("start_busy", 32'(bus.busy), 1);
      chk("start_pc", 32'(bus.pc_out), 0);
      bus.start = 1'b0;
      drive(1'b1, 1'b0, 2'b00, 8'd0);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("count_pc", 32'(bus.pc_out), 32'(i));
      end
      drive(1'b0, 1'b0, 2'b00, 8'd0);
      step();
      chk("idle_hold_pc", 32'(bus.pc_out), 3);

      drive(1'b1, 1'b1, 2'b00, 8'd10);  step(); chk("abs10", 32'(bus.pc_out), 10);
      drive(1'b1, 1'b1, 2'b01, 8'hFC);  step(); chk("rel_neg4", 32'(bus.pc_out), 6);
      drive(1'b1, 1'b1, 2'b00, 8'd255); step(); chk("abs255", 32'(bus.pc_out), 255);
      drive(1'b1, 1'b1, 2'b01, 8'd127); step(); chk("rel127a", 32'(bus.pc_out), 382);
      drive(1'b1, 1'b1, 2'b01, 8'd127); step(); chk("rel127b", 32'(bus.pc_out), 509);
      drive(1'b1, 1'b0, 2'b00, 8'd0);
      step(); step();
      chk("pc511", 32'(bus.pc_out), 511);
      step(); chk("wrap0", 32'(bus.pc_out), 0);

      drive(1'b1, 1'b1, 2'b00, 8'd5);  step(); chk("abs5", 32'(bus.pc_out), 5);
      drive(1'b1, 1'b1, 2'b10, 8'd20); step(); chk("call1", 32'(bus.pc_out), 20);
      drive(1'b1, 1'b1, 2'b10, 8'd30); step(); chk("call2", 32'(bus.pc_out), 30);
      drive(1'b1, 1'b1, 2'b10, 8'd40); step(); chk("call3", 32'(bus.pc_out), 40);
      drive(1'b1, 1'b1, 2'b10, 8'd50); step(); chk("call4", 32'(bus.pc_out), 50);
      chk("ovf_before_full", 32'(bus.stack_overflow), 0);
      drive(1'b1, 1'b1, 2'b10, 8'd60); step();
      chk("call5_pc", 32'(bus.pc_out), 51);
      chk("call5_ovf", 32'(bus.stack_overflow), 1);
      drive(1'b1, 1'b1, 2'b11, 8'd0);
      step(); chk("ret1", 32'(bus.pc_out), 41);
      step(); chk("ret2", 32'(bus.pc_out), 31);
      step(); chk("ret3", 32'(bus.pc_out), 21);
      step(); chk("ret4", 32'(bus.pc_out), 6);
      chk("unf_before_empty", 32'(bus.stack_underflow), 0);
      drive(1'b1, 1'b0, 2'b00, 8'd0); step(); chk("pc7", 32'(bus.pc_out), 7);
      drive(1'b1, 1'b1, 2'b11, 8'd0); step();
      chk("ret_empty_pc", 32'(bus.pc_out), 8);
      chk("ret_empty_unf", 32'(bus.stack_underflow), 1);
      drive(1'b1, 1'b0, 2'b00, 8'd0); step();
      chk("unf_sticky", 32'(bus.stack_underflow), 1);
      chk("ovf_sticky", 32'(bus.stack_overflow), 1);
      chk("pc9", 32'(bus.pc_out), 9);
      bus.stall = 1'b1; step();
      chk("stall_hold", 32'(bus.pc_out), 9);
      bus.stall = 1'b0;
      bus.start = 1'b1; step();
      chk("start_ignored_run", 32'(bus.pc_out), 10);
      chk("start_ignored_ovf", 32'(bus.stack_overflow), 1);
      bus.start = 1'b0;

      drive(1'b1, 1'b1, 2'b00, 8'd200); step(); chk("abs200", 32'(bus.pc_out), 200);
      drive(1'b1, 1'b1, 2'b01, 8'd127); step(); chk("rel327", 32'(bus.pc_out), 327);
      drive(1'b1, 1'b1, 2'b01, 8'd108); step();
      chk("reach435", 32'(bus.pc_out), 435);
      chk("reach435_busy", 32'(bus.busy), 1);
      drive(1'b1, 1'b1, 2'b00, 8'd7); step();
      chk("done_flag", 32'(bus.done), 1);
      chk("done_busy", 32'(bus.busy), 0);
      chk("done_pc", 32'(bus.pc_out), 435);
      step();
      chk("done_hold_pc", 32'(bus.pc_out), 435);
      drive(1'b1, 1'b0, 2'b00, 8'd0);
      bus.start = 1'b1; step();
      bus.start = 1'b0;
      chk("restart_pc", 32'(bus.pc_out), 0);
      chk("restart_busy", 32'(bus.busy), 1);
      chk("restart_done", 32'(bus.done), 0);
      chk("restart_ovf", 32'(bus.stack_overflow), 0);
      chk("restart_unf", 32'(bus.stack_underflow), 0);
      step(); step();
      chk("restart_count", 32'(bus.pc_out), 2);

      drive(1'b1, 1'b1, 2'b10, 8'd90); step(); chk("call_pre_reset", 32'(bus.pc_out), 90);
      reset_n = 1'b0; step();
      chk("mid_rst_pc", 32'(bus.pc_out), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_done", 32'(bus.done), 0);
      reset_n = 1'b1;
      drive(1'b1, 1'b1, 2'b11, 8'd0);
      step();
      chk("idle_no_advance", 32'(bus.pc_out), 0);
      bus.start = 1'b1; step(); bus.start = 1'b0;
      step();
      chk("stack_cleared_pc", 32'(bus.pc_out), 1);
      chk("stack_cleared_unf", 32'(bus.stack_underflow), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
